mips_fetch_unit: RTL and testbench
==================================

# mips_fetch_unit

Instruction-fetch and next-PC sequencer for the single-cycle-style MIPS datapath. Owns the PC register, fetches a word from instruction memory over a ready/req handshake, and splits the held instruction into the `opcode`/`funct` and register/immediate fields that `mips_decode` consumes. It then takes `control_type` back from the decoder and forms the next PC (sequential, branch, jump, or jr) when the datapath acknowledges the instruction.

## Interface

**Parameters**
- `RESET_PC`, default `32'h0040_0000`: PC loaded on reset.
- `EXC_VECTOR`, default `32'h8000_0180`: PC loaded when `except` is taken.

**Ports**
- Reset style (fixed): one clock; reset is synchronous and active-high.
- `clock`, input, 1: sole clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high.
- `imem_req`, output, 1: fetch request to instruction memory.
- `imem_addr`, output, 32: byte address of the fetch; always equals `pc`, with bits [1:0] equal to 0.
- `imem_ready`, input, 1: `imem_rdata` is valid this cycle.
- `imem_rdata`, input, 32: fetched instruction word.
- `inst_valid`, output, 1: the instruction register holds an instruction awaiting issue.
- `opcode`, output, 6: `IR[31:26]`.
- `funct`, output, 6: `IR[5:0]`.
- `rs`, output, 5: `IR[25:21]`.
- `rt`, output, 5: `IR[20:16]`.
- `rd`, output, 5: `IR[15:11]`.
- `imm16`, output, 16: `IR[15:0]`.
- `pc`, output, 32: address of the current instruction.
- `pc_plus4`, output, 32: `pc + 4`.
- `control_type`, input, 2: from `mips_decode`; 0 = sequential, 1 = branch taken, 2 = j, 3 = jr.
- `rs_data`, input, 32: register-file read of `rs`; used as the jr target.
- `except`, input, 1: from `mips_decode`.
- `issue_ack`, input, 1: the datapath has executed the held instruction.
- `inst_count`, output, 32: retired-instruction count (see Configuration).
- `stall_count`, output, 32: cycles spent waiting on `imem_ready` (see Configuration).

## Operation

**States:** `IDLE`, `FETCH`, `ISSUE`.

- **IDLE**
  - Entered on reset; stays exactly one cycle, then moves to `FETCH`.
- **FETCH**
  - `imem_req` = 1.
  - On `imem_ready`: capture `imem_rdata` into IR and go to `ISSUE`.
  - Otherwise: stay in `FETCH`.
- **ISSUE**
  - `inst_valid` = 1.
  - On `issue_ack`: load the next PC, go to `FETCH`.
  - Otherwise: hold IR and PC unchanged.

**Next PC:**
- If `except` = 1: `EXC_VECTOR`, regardless of `control_type`.
- Otherwise, by `control_type`:
  - 0: `pc_plus4`.
  - 1: `pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00}`.
  - 2: `{pc_plus4[31:28], IR[25:0], 2'b00}`.
  - 3: `{rs_data[31:2], 2'b00}`; the low bits are forced to 0.

**Width and wrap rules:**
- All adds are 32-bit modulo; `0xFFFF_FFFC + 4` wraps to 0.

**Boundary conditions:**
- `imem_ready` is ignored outside `FETCH`.
- `issue_ack`, `except` and `control_type` are ignored outside `ISSUE`.
- `except` and `issue_ack` in the same cycle: the exception vector wins.
- `except` without `issue_ack`: no effect.
- Reset during `FETCH` abandons the request: `imem_req` is 0 on the cycle after reset.

## Timing

**Reset values:**
- `pc` = `RESET_PC`; IR = 0, so all field outputs are 0.
- `inst_valid` = 0, `imem_req` = 0.
- Both counters = 0; state = `IDLE`.

**Latency:**
- Cycle 0 is the first cycle after reset deasserts (state `IDLE`).
- `imem_req` rises in cycle 1.
- If `imem_ready` is high in cycle 1, `inst_valid` rises in cycle 2.
- Issue to next request: `issue_ack` sampled high at edge N → new `pc` and `imem_req` = 1 during cycle N+1.

**Throughput:**
- At best, one instruction every 2 cycles (one `FETCH` cycle plus one `ISSUE` cycle).

**Output timing:**
- All outputs are registered or are decodes of state; no combinational path from an input to `imem_req` or `inst_valid`.
- `imem_addr` and the field outputs are stable for as long as `imem_req` or `inst_valid` is held.

## Configuration

**`FETCH_PERF_COUNT_EN`**

- **Defined:**
  - `inst_count` increments on every accepted `issue_ack` in `ISSUE`.
  - `stall_count` increments on every `FETCH` cycle with `imem_ready` = 0.
  - Both wrap at 2^32 and clear on reset.
- **Undefined:** both outputs are tied to 0 and no counter flops are built.

## Test plan

1. **Reset and sequential fetch.** Reset, `imem_ready` always high, issue two instructions with `control_type` = 0.
   - `imem_addr` = `0x0040_0000`, then `0x0040_0004`.
   - `inst_valid` first high in cycle 2.
2. **Memory stall.** `imem_ready` low for 3 cycles, then high with `0x0109_4020` (add).
   - `opcode` = 0, `funct` = `0x20`, `rs` = 8, `rt` = 9, `rd` = 8.
   - `stall_count` = 3 when the macro is defined.
3. **Branch.** `pc` = `0x0040_0010`, IR `imm16` = `0xFFFE`, `control_type` = 1.
   - Next `pc` = `0x0040_000C`.
   - Repeat with `imm16` = `0x0003` → `0x0040_0020`.
4. **Jump and jr.**
   - j: `pc` = `0x0040_0000`, `IR[25:0]` = `0x010_0008` → next `pc` = `0x0040_0020`.
   - jr: `rs_data` = `0x0040_0103` → next `pc` = `0x0040_0100`.
5. **Exception.**
   - `except` and `issue_ack` together with `control_type` = 2 → next `pc` = `0x8000_0180`.
   - `except` alone while `issue_ack` = 0 → PC and IR unchanged.
6. **Reset mid-fetch.** Assert `reset` while in `FETCH` with `imem_ready` = 0.
   - Next cycle: `imem_req` = 0, `pc` = `0x0040_0000`, `inst_valid` = 0, counters = 0.

Source files
------------

// File: rtl/mips_fetch_unit.sv
// MIPS instruction-fetch and next-PC sequencer: owns PC and IR, fetches over a req/ready handshake.
// Optional FETCH_PERF_COUNT_EN builds retired-instruction and fetch-stall counters.
module mips_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0040_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0180
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [15:0] imm16,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic [1:0]  control_type,
  input  logic [31:0] rs_data,
  input  logic        except,
  input  logic        issue_ack,
  output logic [31:0] inst_count,
  output logic [31:0] stall_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    CT_SEQ    = 2'd0,
    CT_BRANCH = 2'd1,
    CT_JUMP   = 2'd2,
    CT_JR     = 2'd3
  } ctrl_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic        req_q, req_d;
  logic        valid_q, valid_d;
  logic [31:0] next_pc;
  logic [31:0] branch_off;

  assign pc_plus4   = pc_q + 32'd4;
  assign branch_off = {{14{ir_q[15]}}, ir_q[15:0], 2'b00};

  always_comb begin
    unique case (ctrl_e'(control_type))
      CT_SEQ:    next_pc = pc_plus4;
      CT_BRANCH: next_pc = pc_plus4 + branch_off;
      CT_JUMP:   next_pc = {pc_plus4[31:28], ir_q[25:0], 2'b00};
      CT_JR:     next_pc = rs_data & 32'hFFFF_FFFC;
      default:   next_pc = pc_plus4;
    endcase
    if (except) next_pc = EXC_VECTOR;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    req_d   = req_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
        req_d   = 1'b1;
        valid_d = 1'b0;
      end
      FETCH: begin
        if (imem_ready) begin
          ir_d    = imem_rdata;
          state_d = ISSUE;
          req_d   = 1'b0;
          valid_d = 1'b1;
        end
      end
      ISSUE: begin
        if (issue_ack) begin
          pc_d    = next_pc;
          state_d = FETCH;
          req_d   = 1'b1;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      req_q   <= req_d;
      valid_q <= valid_d;
    end
  end

  assign imem_req   = req_q;
  assign imem_addr  = pc_q;
  assign inst_valid = valid_q;
  assign pc         = pc_q;
  assign opcode     = ir_q[31:26];
  assign rs         = ir_q[25:21];
  assign rt         = ir_q[20:16];
  assign rd         = ir_q[15:11];
  assign imm16      = ir_q[15:0];
  assign funct      = ir_q[5:0];

`ifdef FETCH_PERF_COUNT_EN
  logic [31:0] inst_count_q, inst_count_d;
  logic [31:0] stall_count_q, stall_count_d;

  always_comb begin
    inst_count_d  = inst_count_q;
    stall_count_d = stall_count_q;
    if (state_q == ISSUE && issue_ack)   inst_count_d  = inst_count_q + 32'd1;
    if (state_q == FETCH && !imem_ready) stall_count_d = stall_count_q + 32'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      inst_count_q  <= '0;
      stall_count_q <= '0;
    end else begin
      inst_count_q  <= inst_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign inst_count  = inst_count_q;
  assign stall_count = stall_count_q;
`else
  assign inst_count  = '0;
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Directed bench for mips_fetch_unit: expected fetch addresses go through a scoreboard queue,
// pushed at each issue and popped when the DUT raises imem_req.
module tb_mips_fetch_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        inst_valid;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm16;
  logic [31:0] pc, pc_plus4;
  logic [1:0]  control_type = '0;
  logic [31:0] rs_data = '0;
  logic        except = 1'b0;
  logic        issue_ack = 1'b0;
  logic [31:0] inst_count, stall_count;

  logic [31:0] exp_q[$];
  int n_cmp  = 0;
  int n_err  = 0;
  int issued = 0;

  mips_fetch_unit dut (
    .clock(clock), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid),
    .opcode(opcode), .funct(funct), .rs(rs), .rt(rt), .rd(rd), .imm16(imm16),
    .pc(pc), .pc_plus4(pc_plus4),
    .control_type(control_type), .rs_data(rs_data),
    .except(except), .issue_ack(issue_ack),
    .inst_count(inst_count), .stall_count(stall_count)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] perf(input logic [31:0] v);
`ifdef FETCH_PERF_COUNT_EN
    return v;
`else
    return 32'd0 & v;
`endif
  endfunction

  task automatic do_reset();
    reset        = 1'b1;
    imem_ready   = 1'b0;
    imem_rdata   = '0;
    issue_ack    = 1'b0;
    except       = 1'b0;
    control_type = '0;
    rs_data      = '0;
    repeat (2) @(negedge clock);
    check("rst_pc", pc, 32'h0040_0000);
    check("rst_req", imem_req, 0);
    check("rst_valid", inst_valid, 0);
    check("rst_ir", {opcode, rs, rt, imm16}, 0);
    check("rst_inst_count", inst_count, 0);
    check("rst_stall_count", stall_count, 0);
    exp_q.delete();
    exp_q.push_back(32'h0040_0000);
    issued = 0;
    reset  = 1'b0;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!imem_req && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("req_timeout", imem_req, 1);
  endtask

  task automatic check_addr();
    logic [31:0] e;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
    check("imem_addr", imem_addr, e);
  endtask

  task automatic fetch(input logic [31:0] word);
    wait_req();
    check_addr();
    imem_ready = 1'b1;
    imem_rdata = word;
    @(negedge clock);
    imem_ready = 1'b0;
    imem_rdata = '0;
    check("fetch_valid", inst_valid, 1);
    check("fetch_ir", {opcode, rs, rt, imm16}, word);
  endtask

  task automatic issue(input logic [1:0] ct, input logic [31:0] rsd, input logic exc,
                       input logic [31:0] exp_next);
    control_type = ct;
    rs_data      = rsd;
    except       = exc;
    issue_ack    = 1'b1;
    exp_q.push_back(exp_next);
    issued++;
    @(negedge clock);
    issue_ack    = 1'b0;
    except       = 1'b0;
    control_type = '0;
    check("next_pc", pc, exp_next);
    check("ack_req", imem_req, 1);
    check("ack_valid", inst_valid, 0);
  endtask

  initial begin
    // Reset and sequential fetch; imem_ready high during IDLE must be ignored
    do_reset();
    imem_ready = 1'b1;
    imem_rdata = 32'h2408_0001;
    @(negedge clock);
    check("c1_req", imem_req, 1);
    check("c1_valid", inst_valid, 0);
    check_addr();
    @(negedge clock);
    check("c2_valid", inst_valid, 1);
    check("c2_req", imem_req, 0);
    check("c2_opcode", opcode, 6'h09);
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge clock);
    check("issue_hold_ir", imm16, 16'h0001);
    imem_ready = 1'b0;
    issue(2'd0, '0, 1'b0, 32'h0040_0004);
    fetch(32'h2409_0002);
    issue(2'd0, '0, 1'b0, 32'h0040_0008);

    // Memory stall of three cycles, then an add
    do_reset();
    @(negedge clock);
    check("st_req", imem_req, 1);
    check_addr();
    repeat (2) @(negedge clock);
    check("st_req_hold", imem_req, 1);
    check("st_valid", inst_valid, 0);
    check("st_addr_hold", imem_addr, 32'h0040_0000);
    @(negedge clock);
    imem_ready = 1'b1;
    imem_rdata = 32'h0109_4020;
    @(negedge clock);
    imem_ready = 1'b0;
    check("st_opcode", opcode, 0);
    check("st_funct", funct, 6'h20);
    check("st_rs", rs, 8);
    check("st_rt", rt, 9);
    check("st_rd", rd, 8);
    check("st_stall_count", stall_count, perf(32'd3));
    issue(2'd0, '0, 1'b0, 32'h0040_0004);

    // Branches backward and forward from pc 0x0040_0010
    fetch(32'h0000_0000); issue(2'd0, '0, 1'b0, 32'h0040_0008);
    fetch(32'h0000_0000); issue(2'd0, '0, 1'b0, 32'h0040_000C);
    fetch(32'h0000_0000); issue(2'd0, '0, 1'b0, 32'h0040_0010);
    fetch(32'h1000_FFFE); issue(2'd1, '0, 1'b0, 32'h0040_000C);
    fetch(32'h0000_0000); issue(2'd0, '0, 1'b0, 32'h0040_0010);
    fetch(32'h1000_0003); issue(2'd1, '0, 1'b0, 32'h0040_0020);

    // Jump and jr (jr target low bits forced to zero)
    fetch(32'h0810_0008); issue(2'd2, '0, 1'b0, 32'h0040_0020);
    fetch(32'h0100_0008); issue(2'd3, 32'h0040_0103, 1'b0, 32'h0040_0100);

    // Exception with ack wins over jump; exception without ack changes nothing
    fetch(32'h0810_0008); issue(2'd2, '0, 1'b1, 32'h8000_0180);
    fetch(32'h2108_0004);
    except       = 1'b1;
    control_type = 2'd2;
    repeat (2) @(negedge clock);
    check("exc_noack_pc", pc, 32'h8000_0180);
    check("exc_noack_valid", inst_valid, 1);
    check("exc_noack_req", imem_req, 0);
    check("exc_noack_ir", {opcode, rs, rt, imm16}, 32'h2108_0004);
    except = 1'b0;
    issue(2'd0, '0, 1'b0, 32'h8000_0184);

    // PC wrap at the top of the address space
    fetch(32'h0100_0008); issue(2'd3, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFC);
    check("wrap_pc_plus4", pc_plus4, 32'h0000_0000);
    fetch(32'h0000_0000); issue(2'd0, '0, 1'b0, 32'h0000_0000);
    check("inst_count", inst_count, perf(issued));
    check("stall_count_kept", stall_count, perf(32'd3));

    // Reset in FETCH abandons the request
    wait_req();
    check_addr();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("rf_req", imem_req, 0);
    check("rf_pc", pc, 32'h0040_0000);
    check("rf_valid", inst_valid, 0);
    check("rf_inst_count", inst_count, 0);
    check("rf_stall_count", stall_count, 0);
    reset = 1'b0;
    exp_q.delete();
    exp_q.push_back(32'h0040_0000);
    @(negedge clock);
    wait_req();
    check_addr();
    check("sb_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
